// File: rtl/us_sensor_pkg.sv
// Shared types and timing defaults for the HC-SR04 driver/emulator pair.
// Durations are expressed in microseconds and scaled by CYC_PER_US.
package us_sensor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HI,
        BURST,
        ECHO,
        HOLDOFF
    } state_t;

    typedef logic [15:0] width_t;

    localparam int DEF_CLK_HZ      = 50_000_000;
    localparam int CYC_PER_US      = DEF_CLK_HZ / 1_000_000;
    localparam int DEF_MIN_TRIG_US = 10;
    localparam int DEF_BURST_US    = 200;
    localparam int DEF_US_PER_CM   = 58;
    localparam int DEF_TIMEOUT_US  = 38000;
    localparam int DEF_HOLDOFF_US  = 10000;

    // Round-trip echo width in us; zero distance reports the no-object timeout.
    function automatic width_t echo_width_us(
        input logic [7:0] cm,
        input width_t     us_per_cm,
        input width_t     timeout_us
    );
        if (cm == 8'd0) begin
            return timeout_us;
        end
        return width_t'(cm) * us_per_cm;
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: us_tick is high on the last cycle of every
// CYC_PER_US-cycle window; clr restarts the window on the next cycle.
module us_tick_gen #(
    parameter int CYC_PER_US = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic us_tick
);

    localparam int CW = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYC_PER_US - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        us_tick = (cnt_q == LAST);
        cnt_d   = cnt_q + 1'b1;
        if (clr || us_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hcsr04_echo_emulator.sv
// HC-SR04 responder: measures the trigger pulse and answers with an echo
// whose width encodes the distance latched at the trigger fall.
module hcsr04_echo_emulator
    import us_sensor_pkg::*;
#(
    parameter int CLK_HZ      = DEF_CLK_HZ,
    parameter int MIN_TRIG_US = DEF_MIN_TRIG_US,
    parameter int BURST_US    = DEF_BURST_US,
    parameter int US_PER_CM   = DEF_US_PER_CM,
    parameter int TIMEOUT_US  = DEF_TIMEOUT_US,
    parameter int HOLDOFF_US  = DEF_HOLDOFF_US
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       trig,
    input  logic [7:0] distance_cm,
    input  logic       enable,
    output logic       echo,
    output logic       busy,
    output logic [7:0] latched_cm,
    output logic       meas_done,
    output logic       short_trig
);

    localparam int     CYC       = CLK_HZ / 1_000_000;
    localparam width_t MIN_W     = width_t'(MIN_TRIG_US);
    localparam width_t BURST_W   = width_t'(BURST_US);
    localparam width_t UPC_W     = width_t'(US_PER_CM);
    localparam width_t TIMEOUT_W = width_t'(TIMEOUT_US);
    localparam width_t HOLDOFF_W = width_t'(HOLDOFF_US);

    state_t     state_q, state_d;
    width_t     us_cnt_q, us_cnt_d;
    logic [7:0] latched_q, latched_d;
    logic       trig_m_q, trig_m_d;
    logic       trig_s_q, trig_s_d;
    logic       trig_p_q, trig_p_d;
    logic       echo_q, echo_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       short_q, short_d;

    logic   us_tick;
    logic   clr;
    logic   rise;
    logic   fall;
    width_t trig_us;
    width_t echo_w;

    assign clr = (state_d != state_q);

    us_tick_gen #(
        .CYC_PER_US(CYC)
    ) u_tick (
        .clk    (CLOCK_50),
        .reset  (reset),
        .clr    (clr),
        .us_tick(us_tick)
    );

    always_comb begin
        trig_m_d = trig;
        trig_s_d = trig_m_q;
        trig_p_d = trig_s_q;
        rise     = trig_s_q & ~trig_p_q;
        fall     = ~trig_s_q & trig_p_q;
        echo_w   = echo_width_us(latched_q, UPC_W, TIMEOUT_W);
        // High time includes the tick landing on the fall-detect cycle.
        trig_us  = us_cnt_q + width_t'(us_tick);
        if (us_cnt_q >= MIN_W) begin
            trig_us = MIN_W;
        end
    end

    always_comb begin
        state_d   = state_q;
        us_cnt_d  = us_cnt_q;
        latched_d = latched_q;
        short_d   = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise && enable) begin
                    state_d = TRIG_HI;
                end
            end
            TRIG_HI: begin
                if (fall) begin
                    if (trig_us >= MIN_W) begin
                        latched_d = distance_cm;
                        state_d   = BURST;
                    end else begin
                        short_d = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    us_cnt_d = trig_us;
                end
            end
            BURST: begin
                if (us_tick) begin
                    us_cnt_d = us_cnt_q + 16'd1;
                    if (us_cnt_q == BURST_W - 16'd1) begin
                        state_d = ECHO;
                    end
                end
            end
            ECHO: begin
                if (us_tick) begin
                    us_cnt_d = us_cnt_q + 16'd1;
                    if (us_cnt_q == echo_w - 16'd1) begin
                        done_d  = 1'b1;
                        state_d = HOLDOFF;
                    end
                end
            end
            HOLDOFF: begin
                if (us_tick) begin
                    us_cnt_d = us_cnt_q + 16'd1;
                    if (us_cnt_q == HOLDOFF_W - 16'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (clr) begin
            us_cnt_d = '0;
        end
        echo_d = (state_d == ECHO);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            us_cnt_q  <= '0;
            latched_q <= '0;
            trig_m_q  <= 1'b0;
            trig_s_q  <= 1'b0;
            trig_p_q  <= 1'b0;
            echo_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            short_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            us_cnt_q  <= us_cnt_d;
            latched_q <= latched_d;
            trig_m_q  <= trig_m_d;
            trig_s_q  <= trig_s_d;
            trig_p_q  <= trig_p_d;
            echo_q    <= echo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            short_q   <= short_d;
        end
    end

    assign echo       = echo_q;
    assign busy       = busy_q;
    assign latched_cm = latched_q;
    assign meas_done  = done_q;
    assign short_trig = short_q;

endmodule

// File: tb/tb_hcsr04_echo_emulator.sv
// Randomized scoreboard bench for the echo emulator, run with a scaled
// timebase so whole measurements stay short.
module tb_hcsr04_echo_emulator;

    localparam int CLK_HZ = 4_000_000;
    localparam int CYC    = CLK_HZ / 1_000_000;
    localparam int MIN    = 10;
    localparam int BUR    = 20;
    localparam int UPC    = 3;
    localparam int TO     = 800;
    localparam int HO     = 50;
    localparam int LAT_LO = BUR * CYC + 2;
    localparam int LAT_HI = BUR * CYC + 3;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b0;
    logic       trig = 1'b0;
    logic       enable = 1'b1;
    logic [7:0] distance_cm = 8'd0;
    logic       echo;
    logic       busy;
    logic [7:0] latched_cm;
    logic       meas_done;
    logic       short_trig;

    hcsr04_echo_emulator #(
        .CLK_HZ     (CLK_HZ),
        .MIN_TRIG_US(MIN),
        .BURST_US   (BUR),
        .US_PER_CM  (UPC),
        .TIMEOUT_US (TO),
        .HOLDOFF_US (HO)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .trig       (trig),
        .distance_cm(distance_cm),
        .enable     (enable),
        .echo       (echo),
        .busy       (busy),
        .latched_cm (latched_cm),
        .meas_done  (meas_done),
        .short_trig (short_trig)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct {
        bit is_echo;
        int width;
        int cm;
        int pin_fall;
    } exp_t;

    exp_t q[$];
    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Echo length in clock cycles from the sensor's distance rule.
    function automatic int model_width(input int cm);
        int us;
        us = (cm == 0) ? TO : cm * UPC;
        return us * CYC;
    endfunction

    initial begin : monitor
        bit   in_echo;
        int   rise_c;
        int   lat;
        exp_t e;
        in_echo = 0;
        rise_c  = 0;
        forever begin
            @(negedge CLOCK_50);
            if (reset) begin
                in_echo = 0;
                continue;
            end
            if (short_trig) begin
                if (q.size() == 0) begin
                    chk("short_unexpected", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("short_kind", int'(e.is_echo), 0);
                end
            end
            if (echo && !in_echo) begin
                in_echo = 1;
                rise_c  = cyc;
                if (q.size() == 0 || !q[0].is_echo) begin
                    chk("echo_unexpected", 1, 0);
                end else begin
                    lat = cyc - q[0].pin_fall;
                    compared++;
                    if (lat < LAT_LO || lat > LAT_HI) begin
                        mismatched++;
                        $display("FAIL echo_latency: got %0d expected %0d..%0d",
                                 lat, LAT_LO, LAT_HI);
                    end
                end
            end else if (!echo && in_echo) begin
                in_echo = 0;
                chk("meas_done_at_fall", int'(meas_done), 1);
                if (q.size() > 0 && q[0].is_echo) begin
                    e = q.pop_front();
                    chk("echo_width", cyc - rise_c, e.width);
                    chk("latched_cm", int'(latched_cm), e.cm);
                end
            end else if (meas_done) begin
                chk("meas_done_stray", 1, 0);
            end
        end
    end

    task automatic pulse(input int us);
        @(negedge CLOCK_50);
        trig = 1'b1;
        repeat (us * CYC) @(negedge CLOCK_50);
        trig = 1'b0;
    endtask

    task automatic issue(input int us, input int cm);
        exp_t e;
        distance_cm = 8'(cm);
        enable      = 1'b1;
        pulse(us);
        e.is_echo  = (us >= MIN);
        e.width    = model_width(cm);
        e.cm       = cm;
        e.pin_fall = cyc + 1;
        q.push_back(e);
        repeat (5) @(negedge CLOCK_50);
        distance_cm = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (4) @(negedge CLOCK_50);
        while (busy && n < 20000) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (n >= 20000) chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_echo(input logic v);
        int n;
        n = 0;
        while (echo !== v && n < 10000) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (n >= 10000) chk("echo_wait_timeout", 1, 0);
    endtask

    initial begin : driver
        int us;
        int cm;
        #2 reset = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        chk("rst_echo", int'(echo), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_latched", int'(latched_cm), 0);
        chk("rst_meas_done", int'(meas_done), 0);
        chk("rst_short", int'(short_trig), 0);
        reset = 1'b0;
        repeat (3) @(negedge CLOCK_50);

        issue(12, 100);
        wait_idle();
        issue(5, 100);
        wait_idle();
        chk("short_back_idle", int'(busy), 0);
        issue(12, 77);
        wait_idle();
        issue(12, 0);
        wait_idle();
        issue(10, 1);
        wait_idle();
        issue(9, 255);
        wait_idle();

        // Rising edge while disabled stays ignored after enable returns.
        enable = 1'b0;
        @(negedge CLOCK_50);
        trig = 1'b1;
        repeat (3 * CYC) @(negedge CLOCK_50);
        enable = 1'b1;
        repeat (10 * CYC) @(negedge CLOCK_50);
        trig = 1'b0;
        repeat (10) @(negedge CLOCK_50);
        chk("disabled_busy", int'(busy), 0);

        // Triggers during ECHO/HOLDOFF and distance changes are ignored.
        issue(12, 20);
        distance_cm = 8'd200;
        wait_echo(1'b1);
        pulse(12);
        wait_echo(1'b0);
        pulse(3);
        @(negedge CLOCK_50);
        trig = 1'b1;
        repeat (HO * CYC) @(negedge CLOCK_50);
        trig = 1'b0;
        wait_idle();
        issue(12, 200);
        wait_idle();

        // Reset in the middle of an echo.
        issue(12, 50);
        wait_echo(1'b1);
        repeat (20) @(negedge CLOCK_50);
        #1 reset = 1'b1;
        #1;
        chk("midreset_echo", int'(echo), 0);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_latched", int'(latched_cm), 0);
        q.delete();
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        issue(11, 60);
        wait_idle();

        for (int i = 0; i < 12; i++) begin
            us = $urandom_range(1, 16);
            cm = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
            issue(us, cm);
            wait_idle();
        end

        repeat (20) @(negedge CLOCK_50);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
